// File: rtl/dmem_arbiter.sv
// Two-port (core / DMA) arbiter in front of the single-ported data_mem.
// Define DMEM_ARB_MISALIGN_CHK_EN to also reject misaligned half/word accesses.
module dmem_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  c_req,
   input  logic                  c_we,
   input  logic [2:0]            c_funct3,
   input  logic [ADDR_WIDTH-1:0] c_addr,
   input  logic [DATA_WIDTH-1:0] c_wdata,
   output logic                  c_gnt,
   output logic                  c_rvalid,
   output logic [DATA_WIDTH-1:0] c_rdata,
   output logic                  c_err,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [2:0]            d_funct3,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_err,
   output logic                  mem_wr_en,
   output logic [2:0]            mem_funct3,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic {CORE_PRI, DMA_PRI} state_t;

   localparam logic [3:0] L_WLIM = 4'(MAX_WAIT - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [3:0]            r_wcnt;
   logic                  w_conflict;
   logic                  w_c_mis;
   logic                  w_d_mis;
   logic                  w_c_rej;
   logic                  w_d_rej;
   logic                  w_rej;
   logic                  w_we;
   logic [DATA_WIDTH-1:0] w_rd;

   function automatic logic f_bad_f3(input logic we, input logic [2:0] f3);
      logic bad;
      if (we) bad = !(f3 inside {3'b000, 3'b001, 3'b010});
      else    bad = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      return bad;
   endfunction

`ifdef DMEM_ARB_MISALIGN_CHK_EN
   assign w_c_mis = ((c_funct3[1:0] == 2'b01) && c_addr[0]) ||
                    ((c_funct3[1:0] == 2'b10) && (c_addr[1:0] != 2'b00));
   assign w_d_mis = ((d_funct3[1:0] == 2'b01) && d_addr[0]) ||
                    ((d_funct3[1:0] == 2'b10) && (d_addr[1:0] != 2'b00));
`else
   assign w_c_mis = 1'b0;
   assign w_d_mis = 1'b0;
`endif

   assign w_c_rej    = f_bad_f3(c_we, c_funct3) | w_c_mis;
   assign w_d_rej    = f_bad_f3(d_we, d_funct3) | w_d_mis;
   assign w_conflict = c_req & d_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= CORE_PRI;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         CORE_PRI:
            if (w_conflict && (r_wcnt == L_WLIM)) w_state_nxt = DMA_PRI;
         DMA_PRI:
            if (d_gnt) w_state_nxt = CORE_PRI;
         default: w_state_nxt = CORE_PRI;
      endcase
   end

   // Grants are gated by rst_n so nothing is granted while reset is held.
   always_comb begin
      c_gnt = 1'b0;
      d_gnt = 1'b0;
      if (rst_n) begin
         if (w_conflict) begin
            c_gnt = (r_state == CORE_PRI);
            d_gnt = (r_state == DMA_PRI);
         end else begin
            c_gnt = c_req;
            d_gnt = d_req;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 r_wcnt <= 4'd0;
      else if (d_req && !d_gnt) begin
         if (r_wcnt != 4'hF)      r_wcnt <= r_wcnt + 4'd1;
      end else                    r_wcnt <= 4'd0;
   end

   always_comb begin
      w_we       = 1'b0;
      w_rej      = 1'b0;
      mem_funct3 = 3'b010;
      mem_addr   = '0;
      mem_wdata  = '0;
      if (c_gnt) begin
         w_we       = c_we;
         w_rej      = w_c_rej;
         mem_funct3 = c_funct3;
         mem_addr   = c_addr;
         mem_wdata  = c_wdata;
      end else if (d_gnt) begin
         w_we       = d_we;
         w_rej      = w_d_rej;
         mem_funct3 = d_funct3;
         mem_addr   = d_addr;
         mem_wdata  = d_wdata;
      end
   end

   assign mem_wr_en = (c_gnt | d_gnt) & w_we & ~w_rej;
   assign w_rd      = (w_we | w_rej) ? '0 : mem_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_rvalid <= 1'b0;
         c_rdata  <= '0;
         c_err    <= 1'b0;
         d_rvalid <= 1'b0;
         d_rdata  <= '0;
         d_err    <= 1'b0;
      end else begin
         c_rvalid <= c_gnt;
         d_rvalid <= d_gnt;
         if (c_gnt) begin
            c_rdata <= w_rd;
            c_err   <= w_rej;
         end
         if (d_gnt) begin
            d_rdata <= w_rd;
            d_err   <= w_rej;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed data_mem model.
// Honors DMEM_ARB_MISALIGN_CHK_EN for the misalignment expectations.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        c_req, c_we, d_req, d_we;
   logic [2:0]  c_funct3, d_funct3;
   logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
   logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
   logic [31:0] c_rdata, d_rdata;
   logic        mem_wr_en;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] mem [0:255] = '{default: 8'h00};

   always #5 clk = ~clk;

   dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .c_req(c_req), .c_we(c_we), .c_funct3(c_funct3), .c_addr(c_addr),
      .c_wdata(c_wdata), .c_gnt(c_gnt), .c_rvalid(c_rvalid),
      .c_rdata(c_rdata), .c_err(c_err),
      .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
      .d_rdata(d_rdata), .d_err(d_err),
      .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // data_mem model: combinational little-endian read, write on rising edge
   always_comb begin
      logic [7:0] a, b0, b1, b2, b3;
      a  = mem_addr[7:0];
      b0 = mem[a];
      b1 = mem[a + 8'd1];
      b2 = mem[a + 8'd2];
      b3 = mem[a + 8'd3];
      mem_rdata = 32'h0;
      case (mem_funct3)
         3'b000: mem_rdata = {{24{b0[7]}}, b0};
         3'b001: mem_rdata = {{16{b1[7]}}, b1, b0};
         3'b010: mem_rdata = {b3, b2, b1, b0};
         3'b100: mem_rdata = {24'h0, b0};
         3'b101: mem_rdata = {16'h0, b1, b0};
         default: mem_rdata = 32'h0;
      endcase
   end

   always @(posedge clk) begin
      if (mem_wr_en) begin
         mem[mem_addr[7:0]] <= mem_wdata[7:0];
         if (mem_funct3[1:0] != 2'b00)
            mem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
         if (mem_funct3[1:0] == 2'b10) begin
            mem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
            mem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic core(input logic rq, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
      c_req = rq; c_we = we; c_funct3 = f3; c_addr = a; c_wdata = wd;
   endtask

   task automatic dma(input logic rq, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
      d_req = rq; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

`ifdef DMEM_ARB_MISALIGN_CHK_EN
   localparam logic        MIS_WE  = 1'b0;
   localparam logic        MIS_ERR = 1'b1;
   localparam logic [31:0] MIS_RD  = 32'h11223344;
`else
   localparam logic        MIS_WE  = 1'b1;
   localparam logic        MIS_ERR = 1'b0;
   localparam logic [31:0] MIS_RD  = 32'h56783344;
`endif

   initial begin
      rst_n = 1'b0;
      core(0, 0, 3'b010, 32'h0, 32'h0);
      dma(0, 0, 3'b010, 32'h0, 32'h0);
      #3;
      chk("rst_c_gnt",   {31'h0, c_gnt}, 32'h0);
      chk("rst_d_gnt",   {31'h0, d_gnt}, 32'h0);
      chk("rst_c_rvalid", {31'h0, c_rvalid}, 32'h0);
      chk("rst_d_rvalid", {31'h0, d_rvalid}, 32'h0);
      chk("rst_c_rdata", c_rdata, 32'h0);
      chk("rst_d_err",   {31'h0, d_err}, 32'h0);
      chk("rst_mem_f3",  {29'h0, mem_funct3}, 32'h2);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_we",  {31'h0, mem_wr_en}, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // core sw 0x10
      core(1, 1, 3'b010, 32'h10, 32'hDEADBEEF);
      #1;
      chk("sw_c_gnt", {31'h0, c_gnt}, 32'h1);
      chk("sw_d_gnt", {31'h0, d_gnt}, 32'h0);
      chk("sw_mem_we", {31'h0, mem_wr_en}, 32'h1);
      chk("sw_mem_addr", mem_addr, 32'h10);
      chk("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
      tick();
      chk("sw_rvalid", {31'h0, c_rvalid}, 32'h1);
      chk("sw_rdata", c_rdata, 32'h0);
      chk("sw_err", {31'h0, c_err}, 32'h0);

      // core lw 0x10
      core(1, 0, 3'b010, 32'h10, 32'h0);
      #1;
      chk("lw_c_gnt", {31'h0, c_gnt}, 32'h1);
      chk("lw_mem_we", {31'h0, mem_wr_en}, 32'h0);
      tick();
      chk("lw_rvalid", {31'h0, c_rvalid}, 32'h1);
      chk("lw_rdata", c_rdata, 32'hDEADBEEF);
      core(0, 0, 3'b010, 32'h0, 32'h0);
      tick();
      chk("idle_rvalid", {31'h0, c_rvalid}, 32'h0);
      chk("idle_rdata_hold", c_rdata, 32'hDEADBEEF);

      // DMA sb 0x13
      dma(1, 1, 3'b000, 32'h13, 32'hA5);
      #1;
      chk("sb_d_gnt", {31'h0, d_gnt}, 32'h1);
      chk("sb_c_gnt", {31'h0, c_gnt}, 32'h0);
      chk("sb_mem_f3", {29'h0, mem_funct3}, 32'h0);
      tick();
      chk("sb_d_rvalid", {31'h0, d_rvalid}, 32'h1);
      chk("sb_c_rvalid", {31'h0, c_rvalid}, 32'h0);
      dma(0, 0, 3'b010, 32'h0, 32'h0);
      core(1, 0, 3'b000, 32'h13, 32'h0);
      tick();
      chk("lb_rdata", c_rdata, 32'hFFFFFFA5);
      chk("lb_d_rvalid", {31'h0, d_rvalid}, 32'h0);
      core(1, 0, 3'b100, 32'h13, 32'h0);
      tick();
      chk("lbu_rdata", c_rdata, 32'h000000A5);
      core(0, 0, 3'b010, 32'h0, 32'h0);

      // invalid funct3: DMA load 011, core store 011
      dma(1, 0, 3'b011, 32'h10, 32'h0);
      #1;
      chk("badld_d_gnt", {31'h0, d_gnt}, 32'h1);
      tick();
      chk("badld_rvalid", {31'h0, d_rvalid}, 32'h1);
      chk("badld_err", {31'h0, d_err}, 32'h1);
      chk("badld_rdata", d_rdata, 32'h0);
      dma(0, 0, 3'b010, 32'h0, 32'h0);
      core(1, 1, 3'b011, 32'h10, 32'h0);
      #1;
      chk("badst_mem_we", {31'h0, mem_wr_en}, 32'h0);
      tick();
      chk("badst_err", {31'h0, c_err}, 32'h1);
      core(1, 0, 3'b010, 32'h10, 32'h0);
      tick();
      chk("badst_noclobber", c_rdata, 32'hA5ADBEEF);
      chk("badst_err_clr", {31'h0, c_err}, 32'h0);

      // misaligned word store
      core(1, 1, 3'b010, 32'h20, 32'h11223344);
      tick();
      core(1, 1, 3'b010, 32'h22, 32'h12345678);
      #1;
      chk("mis_mem_we", {31'h0, mem_wr_en}, {31'h0, MIS_WE});
      tick();
      chk("mis_rvalid", {31'h0, c_rvalid}, 32'h1);
      chk("mis_err", {31'h0, c_err}, {31'h0, MIS_ERR});
      core(1, 0, 3'b010, 32'h20, 32'h0);
      tick();
      chk("mis_lw20", c_rdata, MIS_RD);
      core(0, 0, 3'b010, 32'h0, 32'h0);
      tick();

      // sustained conflict: C,C,C,C,D repeating
      core(1, 0, 3'b010, 32'h0, 32'h0);
      dma(1, 0, 3'b010, 32'h4, 32'h0);
      for (int i = 0; i < 14; i++) begin
         #1;
         chk($sformatf("cf%0d_c_gnt", i), {31'h0, c_gnt},
             {31'h0, (i % 5) != 4});
         chk($sformatf("cf%0d_d_gnt", i), {31'h0, d_gnt},
             {31'h0, (i % 5) == 4});
         chk($sformatf("cf%0d_excl", i), {31'h0, c_gnt & d_gnt}, 32'h0);
         tick();
      end

      // now in DMA_PRI with DMA storing to 0x40; reset mid-access
      dma(1, 1, 3'b010, 32'h40, 32'h99999999);
      #1;
      chk("dpri_d_gnt", {31'h0, d_gnt}, 32'h1);
      chk("dpri_mem_we", {31'h0, mem_wr_en}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("arst_c_gnt", {31'h0, c_gnt}, 32'h0);
      chk("arst_d_gnt", {31'h0, d_gnt}, 32'h0);
      chk("arst_c_rvalid", {31'h0, c_rvalid}, 32'h0);
      chk("arst_d_rvalid", {31'h0, d_rvalid}, 32'h0);
      chk("arst_mem_we", {31'h0, mem_wr_en}, 32'h0);
      chk("arst_c_rdata", c_rdata, 32'h0);
      tick();
      #3;
      rst_n = 1'b1;
      core(1, 0, 3'b010, 32'h40, 32'h0);
      #1;
      chk("post_c_gnt", {31'h0, c_gnt}, 32'h1);
      chk("post_d_gnt", {31'h0, d_gnt}, 32'h0);
      tick();
      chk("post_rvalid", {31'h0, c_rvalid}, 32'h1);
      chk("post_nowrite", c_rdata, 32'h0);
      core(0, 0, 3'b010, 32'h0, 32'h0);
      dma(0, 0, 3'b010, 32'h0, 32'h0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
